// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control sequencer.
//   - opcode constants (IR high nibble)
//   - T-state indices
//   - control-word bit positions, so the strobes can be built as one vector
//   - sequencer state type and the per-opcode final micro-step
package cpu_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam int T0 = 0;
   localparam int T1 = 1;
   localparam int T2 = 2;
   localparam int T3 = 3;
   localparam int T4 = 4;

   localparam int CW_PC_OUT   = 0;
   localparam int CW_PC_INC   = 1;
   localparam int CW_PC_LOAD  = 2;
   localparam int CW_MAR_IN   = 3;
   localparam int CW_RAM_IN   = 4;
   localparam int CW_RAM_OUT  = 5;
   localparam int CW_IR_IN    = 6;
   localparam int CW_IR_OUT   = 7;
   localparam int CW_A_IN     = 8;
   localparam int CW_A_OUT    = 9;
   localparam int CW_B_IN     = 10;
   localparam int CW_ALU_OUT  = 11;
   localparam int CW_ALU_SUB  = 12;
   localparam int CW_OUT_IN   = 13;
   localparam int CW_FLAGS_IN = 14;
   localparam int CW_HALT     = 15;
   localparam int CW_WIDTH    = 16;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } seq_state_e;

   // Micro-step that closes the instruction; undefined opcodes end like NOP.
   function automatic int last_step(input logic [3:0] op);
      case (op)
         OP_LDA, OP_STA: return T3;
         OP_ADD, OP_SUB: return T4;
         default:        return T2;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_step_counter.sv
// T-state counter for the control sequencer.
//   clk_sys  : clock
//   rst_n    : asynchronous active-low clear (count -> 0)
//   restart  : synchronous return to 0 (end of instruction)
//   hold     : freeze the count (halted)
//   step     : current T-state
// The count wraps to 0 after STEP_COUNT-1 even without restart.
module step_counter #(
   parameter int STEP_COUNT = 5,
   parameter int W          = $clog2(STEP_COUNT)
) (
   input  logic         clk_sys,
   input  logic         rst_n,
   input  logic         restart,
   input  logic         hold,
   output logic [W-1:0] step
);

   localparam logic [W-1:0] LAST = W'(STEP_COUNT - 1);

   logic [W-1:0] step_q;
   logic [W-1:0] step_d;

   always_comb begin
      step_d = step_q;
      if (!hold) begin
         if (restart || (step_q >= LAST)) begin
            step_d = '0;
         end else begin
            step_d = step_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         step_q <= '0;
      end else begin
         step_q <= step_d;
      end
   end

   assign step = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Micro-coded control unit: steps T-states through fetch and execute and
// decodes (step, opcode, flags) into one-hot bus strobes.
//   i_CLOCK / i_CLEAR     : clock, async active-low reset
//   i_OPCODE              : IR high nibble, valid from T2
//   i_CARRY / i_ZERO      : latched flags, consulted in T2 only
//   o_* strobes           : PC, MAR, RAM, IR, A, B, ALU, OUT, FLAGS controls
//   o_HALT                : clock-stop request
//   o_STEP                : current T-state
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | fetch/execute; step advances every edge
// ST_HALTED | HLT executed; step frozen, only o_HALT asserted until reset
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 4,
   parameter int STEP_COUNT    = 5
) (
   input  logic                          i_CLOCK,
   input  logic                          i_CLEAR,
   input  logic [ADDRESS_WIDTH-1:0]      i_OPCODE,
   input  logic                          i_CARRY,
   input  logic                          i_ZERO,
   output logic                          o_PC_OUT,
   output logic                          o_PC_INC,
   output logic                          o_PC_LOAD,
   output logic                          o_MAR_IN,
   output logic                          o_RAM_IN,
   output logic                          o_RAM_OUT,
   output logic                          o_IR_IN,
   output logic                          o_IR_OUT,
   output logic                          o_A_IN,
   output logic                          o_A_OUT,
   output logic                          o_B_IN,
   output logic                          o_ALU_OUT,
   output logic                          o_ALU_SUB,
   output logic                          o_OUT_IN,
   output logic                          o_FLAGS_IN,
   output logic                          o_HALT,
   output logic [$clog2(STEP_COUNT)-1:0] o_STEP
);

   localparam int SW = $clog2(STEP_COUNT);

   seq_state_e            state_q;
   seq_state_e            state_d;
   logic [SW-1:0]         step_q;
   logic [3:0]            opcode;
   logic [SW-1:0]         last_s;
   logic [CW_WIDTH-1:0]   cw;
   logic [CW_WIDTH-1:0]   cw_g;
   logic                  halt_req;
   logic                  restart;

   assign opcode   = i_OPCODE[3:0];
   assign last_s   = SW'(last_step(opcode));
   assign halt_req = cw[CW_HALT];
   // last_s is never below T2, so garbage on the opcode during fetch cannot end early
   assign restart  = (state_q == ST_RUN) && (step_q >= last_s);

   step_counter #(
      .STEP_COUNT (STEP_COUNT),
      .W          (SW)
   ) u_step (
      .clk_sys (i_CLOCK),
      .rst_n   (i_CLEAR),
      .restart (restart),
      .hold    (halt_req),
      .step    (step_q)
   );

   always_ff @(posedge i_CLOCK or negedge i_CLEAR) begin
      if (!i_CLEAR) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if ((state_q == ST_RUN) && halt_req) begin
         state_d = ST_HALTED;
      end
   end

   always_comb begin
      cw = '0;
      if (state_q == ST_HALTED) begin
         cw[CW_HALT] = 1'b1;
      end else begin
         case (step_q)
            SW'(T0): begin
               cw[CW_PC_OUT] = 1'b1;
               cw[CW_MAR_IN] = 1'b1;
            end
            SW'(T1): begin
               cw[CW_RAM_OUT] = 1'b1;
               cw[CW_IR_IN]   = 1'b1;
               cw[CW_PC_INC]  = 1'b1;
            end
            SW'(T2): begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     cw[CW_IR_OUT] = 1'b1;
                     cw[CW_MAR_IN] = 1'b1;
                  end
                  OP_LDI: begin
                     cw[CW_IR_OUT] = 1'b1;
                     cw[CW_A_IN]   = 1'b1;
                  end
                  OP_JMP: begin
                     cw[CW_IR_OUT]  = 1'b1;
                     cw[CW_PC_LOAD] = 1'b1;
                  end
                  OP_JC: begin
                     cw[CW_IR_OUT]  = i_CARRY;
                     cw[CW_PC_LOAD] = i_CARRY;
                  end
                  OP_JZ: begin
                     cw[CW_IR_OUT]  = i_ZERO;
                     cw[CW_PC_LOAD] = i_ZERO;
                  end
                  OP_OUT: begin
                     cw[CW_A_OUT]  = 1'b1;
                     cw[CW_OUT_IN] = 1'b1;
                  end
                  OP_HLT: begin
                     cw[CW_HALT] = 1'b1;
                  end
                  default: begin
                  end
               endcase
            end
            SW'(T3): begin
               case (opcode)
                  OP_LDA: begin
                     cw[CW_RAM_OUT] = 1'b1;
                     cw[CW_A_IN]    = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     cw[CW_RAM_OUT] = 1'b1;
                     cw[CW_B_IN]    = 1'b1;
                  end
                  OP_STA: begin
                     cw[CW_A_OUT]  = 1'b1;
                     cw[CW_RAM_IN] = 1'b1;
                  end
                  default: begin
                  end
               endcase
            end
            SW'(T4): begin
               if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                  cw[CW_ALU_OUT]  = 1'b1;
                  cw[CW_A_IN]     = 1'b1;
                  cw[CW_FLAGS_IN] = 1'b1;
                  cw[CW_ALU_SUB]  = (opcode == OP_SUB);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Strobes drop the instant reset asserts, without waiting for an edge.
   assign cw_g = cw & {CW_WIDTH{i_CLEAR}};

   assign o_PC_OUT   = cw_g[CW_PC_OUT];
   assign o_PC_INC   = cw_g[CW_PC_INC];
   assign o_PC_LOAD  = cw_g[CW_PC_LOAD];
   assign o_MAR_IN   = cw_g[CW_MAR_IN];
   assign o_RAM_IN   = cw_g[CW_RAM_IN];
   assign o_RAM_OUT  = cw_g[CW_RAM_OUT];
   assign o_IR_IN    = cw_g[CW_IR_IN];
   assign o_IR_OUT   = cw_g[CW_IR_OUT];
   assign o_A_IN     = cw_g[CW_A_IN];
   assign o_A_OUT    = cw_g[CW_A_OUT];
   assign o_B_IN     = cw_g[CW_B_IN];
   assign o_ALU_OUT  = cw_g[CW_ALU_OUT];
   assign o_ALU_SUB  = cw_g[CW_ALU_SUB];
   assign o_OUT_IN   = cw_g[CW_OUT_IN];
   assign o_FLAGS_IN = cw_g[CW_FLAGS_IN];
   assign o_HALT     = cw_g[CW_HALT];
   assign o_STEP     = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

   logic       i_CLOCK = 1'b0;
   logic       i_CLEAR = 1'b1;
   logic [3:0] i_OPCODE = 4'h0;
   logic       i_CARRY = 1'b0;
   logic       i_ZERO = 1'b0;
   logic o_PC_OUT, o_PC_INC, o_PC_LOAD, o_MAR_IN, o_RAM_IN, o_RAM_OUT;
   logic o_IR_IN, o_IR_OUT, o_A_IN, o_A_OUT, o_B_IN, o_ALU_OUT, o_ALU_SUB;
   logic o_OUT_IN, o_FLAGS_IN, o_HALT;
   logic [2:0] o_STEP;

   int n_checks = 0;
   int n_fail   = 0;
   int m_step   = 0;
   bit m_halted = 1'b0;

   localparam logic [15:0] M_PC_OUT   = 16'h0001;
   localparam logic [15:0] M_PC_INC   = 16'h0002;
   localparam logic [15:0] M_PC_LOAD  = 16'h0004;
   localparam logic [15:0] M_MAR_IN   = 16'h0008;
   localparam logic [15:0] M_RAM_IN   = 16'h0010;
   localparam logic [15:0] M_RAM_OUT  = 16'h0020;
   localparam logic [15:0] M_IR_IN    = 16'h0040;
   localparam logic [15:0] M_IR_OUT   = 16'h0080;
   localparam logic [15:0] M_A_IN     = 16'h0100;
   localparam logic [15:0] M_A_OUT    = 16'h0200;
   localparam logic [15:0] M_B_IN     = 16'h0400;
   localparam logic [15:0] M_ALU_OUT  = 16'h0800;
   localparam logic [15:0] M_ALU_SUB  = 16'h1000;
   localparam logic [15:0] M_OUT_IN   = 16'h2000;
   localparam logic [15:0] M_FLAGS_IN = 16'h4000;
   localparam logic [15:0] M_HALT     = 16'h8000;

   control_sequencer #(
      .ADDRESS_WIDTH (4),
      .STEP_COUNT    (5)
   ) dut (
      .i_CLOCK    (i_CLOCK),
      .i_CLEAR    (i_CLEAR),
      .i_OPCODE   (i_OPCODE),
      .i_CARRY    (i_CARRY),
      .i_ZERO     (i_ZERO),
      .o_PC_OUT   (o_PC_OUT),
      .o_PC_INC   (o_PC_INC),
      .o_PC_LOAD  (o_PC_LOAD),
      .o_MAR_IN   (o_MAR_IN),
      .o_RAM_IN   (o_RAM_IN),
      .o_RAM_OUT  (o_RAM_OUT),
      .o_IR_IN    (o_IR_IN),
      .o_IR_OUT   (o_IR_OUT),
      .o_A_IN     (o_A_IN),
      .o_A_OUT    (o_A_OUT),
      .o_B_IN     (o_B_IN),
      .o_ALU_OUT  (o_ALU_OUT),
      .o_ALU_SUB  (o_ALU_SUB),
      .o_OUT_IN   (o_OUT_IN),
      .o_FLAGS_IN (o_FLAGS_IN),
      .o_HALT     (o_HALT),
      .o_STEP     (o_STEP)
   );

   always #5 i_CLOCK = ~i_CLOCK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   function automatic logic [15:0] outs();
      return {o_HALT, o_FLAGS_IN, o_OUT_IN, o_ALU_SUB, o_ALU_OUT, o_B_IN,
              o_A_OUT, o_A_IN, o_IR_OUT, o_IR_IN, o_RAM_OUT, o_RAM_IN,
              o_MAR_IN, o_PC_LOAD, o_PC_INC, o_PC_OUT};
   endfunction

   // Instruction length in cycles, straight from the instruction table.
   function automatic int instr_len(input logic [3:0] op);
      case (op)
         4'h1, 4'h4: return 4;
         4'h2, 4'h3: return 5;
         default:    return 3;
      endcase
   endfunction

   // Expected strobes for a micro-step as listed in the instruction table.
   function automatic logic [15:0] exp_word(input logic [3:0] op, input int step,
                                            input logic c, input logic z, input bit halted);
      if (halted) return M_HALT;
      if (step == 0) return M_PC_OUT | M_MAR_IN;
      if (step == 1) return M_RAM_OUT | M_IR_IN | M_PC_INC;
      if (step == 2) begin
         case (op)
            4'h1, 4'h2, 4'h3, 4'h4: return M_IR_OUT | M_MAR_IN;
            4'h5: return M_IR_OUT | M_A_IN;
            4'h6: return M_IR_OUT | M_PC_LOAD;
            4'h7: return c ? (M_IR_OUT | M_PC_LOAD) : 16'h0000;
            4'h8: return z ? (M_IR_OUT | M_PC_LOAD) : 16'h0000;
            4'hE: return M_A_OUT | M_OUT_IN;
            4'hF: return M_HALT;
            default: return 16'h0000;
         endcase
      end
      if (step == 3) begin
         case (op)
            4'h1: return M_RAM_OUT | M_A_IN;
            4'h2, 4'h3: return M_RAM_OUT | M_B_IN;
            4'h4: return M_A_OUT | M_RAM_IN;
            default: return 16'h0000;
         endcase
      end
      if (step == 4) begin
         if (op == 4'h2) return M_ALU_OUT | M_A_IN | M_FLAGS_IN;
         if (op == 4'h3) return M_ALU_OUT | M_A_IN | M_FLAGS_IN | M_ALU_SUB;
      end
      return 16'h0000;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: apply inputs, check at the falling edge, advance the model.
   task automatic cycle(input logic [3:0] op, input logic c, input logic z, input string tag);
      i_OPCODE = op;
      i_CARRY  = c;
      i_ZERO   = z;
      @(negedge i_CLOCK);
      check({tag, "_step"}, {13'b0, o_STEP}, 16'(m_step));
      check({tag, "_ctl"}, outs(), exp_word(op, m_step, c, z, m_halted));
      check({tag, "_bus"},
            16'($countones({o_PC_OUT, o_RAM_OUT, o_IR_OUT, o_A_OUT, o_ALU_OUT}) <= 1), 16'd1);
      @(posedge i_CLOCK);
      if (!m_halted) begin
         if (m_step == 2 && op == 4'hF) m_halted = 1'b1;
         else if (m_step >= instr_len(op) - 1) m_step = 0;
         else m_step++;
      end
      #1;
   endtask

   // Whole instruction with separate flag values for T2 and for the other steps.
   task automatic run_instr(input logic [3:0] op, input logic c2, input logic z2,
                            input logic co, input logic zo, input string tag);
      int len;
      len = instr_len(op);
      for (int k = 0; k < len; k++) begin
         if (m_step == 2) cycle(op, c2, z2, tag);
         else             cycle(op, co, zo, tag);
      end
   endtask

   task automatic async_reset(input bit hold_edge, input string tag);
      #2;
      i_CLEAR = 1'b0;
      #1;
      check({tag, "_rst_step"}, {13'b0, o_STEP}, 16'd0);
      check({tag, "_rst_ctl"}, outs(), 16'h0000);
      if (hold_edge) begin
         @(posedge i_CLOCK);
         #1;
         check({tag, "_rst_hold_step"}, {13'b0, o_STEP}, 16'd0);
         check({tag, "_rst_hold_ctl"}, outs(), 16'h0000);
      end
      i_CLEAR  = 1'b1;
      m_step   = 0;
      m_halted = 1'b0;
   endtask

   initial begin
      int n;
      logic [3:0] op;

      // Reset held across several edges
      #2;
      i_CLEAR = 1'b0;
      repeat (2) @(posedge i_CLOCK);
      #1;
      check("reset_step", {13'b0, o_STEP}, 16'd0);
      check("reset_ctl", outs(), 16'h0000);
      i_CLEAR = 1'b1;
      m_step  = 0;

      // Directed instructions, then one extra cycle shows the return to T0
      run_instr(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, "ldi");
      run_instr(4'h2, 1'b0, 1'b0, 1'b1, 1'b1, "add");
      run_instr(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, "sub");
      run_instr(4'h7, 1'b0, 1'b1, 1'b1, 1'b1, "jc_nc");
      run_instr(4'h7, 1'b1, 1'b0, 1'b0, 1'b0, "jc_c");
      run_instr(4'h8, 1'b1, 1'b0, 1'b1, 1'b1, "jz_nz");
      run_instr(4'h8, 1'b0, 1'b1, 1'b0, 1'b0, "jz_z");
      run_instr(4'h1, 1'b0, 1'b0, 1'b0, 1'b0, "lda");
      run_instr(4'h4, 1'b0, 1'b0, 1'b0, 1'b0, "sta");
      run_instr(4'h6, 1'b0, 1'b0, 1'b0, 1'b0, "jmp");
      run_instr(4'hE, 1'b0, 1'b0, 1'b0, 1'b0, "out");
      run_instr(4'h0, 1'b1, 1'b1, 1'b1, 1'b1, "nop");

      // Reset in the middle of LDA T3, held across an edge
      for (int k = 0; k < 3; k++) cycle(4'h1, 1'b0, 1'b0, "lda_abort");
      check("lda_at_t3", {13'b0, o_STEP}, 16'd3);
      async_reset(1'b1, "lda_abort");
      run_instr(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, "after_abort");

      // HLT: frozen at T2 for 20 edges whatever the inputs do
      run_instr(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, "hlt");
      for (int k = 0; k < 20; k++)
         cycle(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), "halted");
      async_reset(1'b0, "hlt_clear");
      run_instr(4'h2, 1'b0, 1'b0, 1'b0, 1'b0, "after_hlt");

      // Opcode sweep with random flags
      for (int o = 0; o < 15; o++)
         run_instr(4'(o), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "sweep");

      // Undefined opcodes: count DUT cycles until o_STEP returns to 0
      for (int o = 9; o < 14; o++) begin
         n = 0;
         do begin
            cycle(4'(o), 1'($urandom), 1'($urandom), "undef");
            n++;
         end while (o_STEP != 3'd0 && n < 10);
         check("undef_len", 16'(n), 16'd3);
      end

      // Random instruction stream; opcode nibble is junk during fetch
      for (int i = 0; i < 150; i++) begin
         op = 4'($urandom_range(0, 14));
         n  = instr_len(op);
         for (int k = 0; k < n; k++) begin
            if (k < 2) cycle(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), "rand");
            else       cycle(op, 1'($urandom), 1'($urandom), "rand");
         end
      end

      // Finish with a halt and a clean restart
      run_instr(4'hF, 1'b1, 1'b1, 1'b1, 1'b1, "hlt2");
      for (int k = 0; k < 3; k++) cycle(4'h0, 1'b0, 1'b0, "halted2");
      async_reset(1'b0, "hlt2_clear");
      cycle(4'h5, 1'b0, 1'b0, "final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
